// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: access sizes, controller states and
// the lane-mask / load-extension helpers. Helpers work at 64 bits so that both
// DW=32 and DW=64 builds can slice what they need.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [0:0] {CLEAR, RUN} state_e;

    // Byte-lane mask for an access of the given size starting at lane offset.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << offset;
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Shift the addressed bytes down to the LSBs, then zero- or sign-extend.
    function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [1:0] size,
                                                input logic [2:0] offset, input logic unsigned_f);
        logic [63:0] sh;
        sh = word >> {offset, 3'b000};
        case (size)
            SZ_B:    return unsigned_f ? {56'b0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            SZ_H:    return unsigned_f ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    return unsigned_f ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DW storage: synchronous per-byte write port, registered read port.
// No reset; contents are cleared by the controller's sweep.
module dmem_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DW/8-1:0]            be,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DW-1:0]              wdata,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DW-1:0]              rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Byte-masked write and registered read on the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: clear sweep after reset, valid/ready request port,
// two-stage registered response (array read, then extend).
// Optional feature: define DMEM_ERR_EN to reject misaligned, oversize and
// out-of-range accesses with rsp_err; otherwise addresses wrap and are aligned.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          init_done
);

    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);

    state_e          state;
    logic [IW-1:0]   cnt;
    logic            init_q;
    logic            accept;
    logic [1:0]      eff_size;
    logic [2:0]      off_raw;
    logic [2:0]      off;
    logic            err;
    logic [IW-1:0]   idx;
    logic [7:0]      be_full;
    logic [DW-1:0]   wrep;

    logic            arr_we;
    logic [NB-1:0]   arr_be;
    logic [IW-1:0]   arr_waddr;
    logic [DW-1:0]   arr_wdata;
    logic            arr_re;
    logic [DW-1:0]   arr_rdata;

    logic            p_valid, p_err, p_load, p_uns;
    logic [1:0]      p_size;
    logic [2:0]      p_off;
    logic [63:0]     ext;

    logic            rsp_valid_q, rsp_err_q;
    logic [DW-1:0]   rsp_rdata_q;

    assign accept    = req_valid & req_ready;
    assign req_ready = init_q;
    assign init_done = init_q;
    assign idx       = req_addr[IW+OB-1:OB];
    assign off_raw   = 3'(req_addr[OB-1:0]);
    assign be_full   = byte_en(eff_size, off);

`ifdef DMEM_ERR_EN
    localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH * NB);
`endif

    // Decode size/offset and, when enabled, the error conditions.
    always_comb begin
        eff_size = req_size;
        if (DW == 32 && req_size == SZ_D) begin
            eff_size = SZ_W;
        end
`ifdef DMEM_ERR_EN
        off = off_raw;
        err = ((off_raw & align_mask(req_size)) != 3'b000)
            || (DW == 32 && req_size == SZ_D)
            || ({1'b0, req_addr} >= LIMIT);
`else
        off = off_raw & ~align_mask(eff_size);
        err = 1'b0;
`endif
    end

    // Replicate right-aligned store data into every lane group of its size.
    always_comb begin
        case (eff_size)
            SZ_B:    wrep = {NB{req_wdata[7:0]}};
            SZ_H:    wrep = {(NB / 2){req_wdata[15:0]}};
            SZ_W:    wrep = {(DW / 32){req_wdata[31:0]}};
            default: wrep = req_wdata;
        endcase
    end

    // Array port mux: the sweep owns the write port until RUN.
    always_comb begin
        arr_we    = 1'b0;
        arr_be    = be_full[NB-1:0];
        arr_waddr = idx;
        arr_wdata = wrep;
        arr_re    = accept & ~req_we & ~err;
        if (state == CLEAR) begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_waddr = cnt;
            arr_wdata = '0;
        end else begin
            arr_we    = accept & req_we & ~err;
        end
    end

    dmem_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .raddr (idx),
        .rdata (arr_rdata)
    );

    // Sweep FSM: one zero write per cycle, then RUN with ready/init_done set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            init_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= RUN;
                        init_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage 1: capture request attributes alongside the array read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_err   <= 1'b0;
            p_load  <= 1'b0;
            p_uns   <= 1'b0;
            p_size  <= SZ_B;
            p_off   <= 3'b000;
        end else begin
            p_valid <= accept;
            p_err   <= accept & err;
            p_load  <= accept & ~req_we & ~err;
            p_uns   <= req_unsigned;
            p_size  <= eff_size;
            p_off   <= off;
        end
    end

    assign ext = load_extend(64'(arr_rdata), p_size, p_off, p_uns);

    // Stage 2: registered response; rdata is zero for stores and errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= p_valid;
            rsp_err_q   <= p_err;
            rsp_rdata_q <= p_load ? ext[DW-1:0] : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Address high bits (wrap mode) and wide helper results are partly unused.
    logic unused_bits;
    assign unused_bits = ^{req_addr, be_full, ext};

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array reference model, directed
// cases and randomized traffic on a DW=32 instance, plus a DW=64 instance.
module tb_dmem_ctrl;

    localparam int DEPTH = 128;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err, init_done;

    logic        w_valid, w_ready, w_we, w_unsigned;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [63:0] w_wdata, w_rdata;
    logic        w_rsp_valid, w_rsp_err, w_init_done;

    dmem_ctrl #(.AW(32), .DW(32), .DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    dmem_ctrl #(.AW(32), .DW(64), .DEPTH(16)) u_dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (w_valid),
        .req_ready    (w_ready),
        .req_we       (w_we),
        .req_size     (w_size),
        .req_unsigned (w_unsigned),
        .req_addr     (w_addr),
        .req_wdata    (w_wdata),
        .rsp_valid    (w_rsp_valid),
        .rsp_rdata    (w_rdata),
        .rsp_err      (w_rsp_err),
        .init_done    (w_init_done)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: flat little-endian byte memory.
    logic [7:0]  mem [BYTES];
    bit          pend_v, pend_err;
    logic [31:0] pend_rdata;

    function automatic int unsigned m_nb(input logic [1:0] size);
        return (size == 2'd3) ? 4 : (1 << size);
    endfunction

    function automatic bit m_err(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_ERR_EN
        return ((addr % (1 << size)) != 0) || (size == 2'd3) || (addr >= BYTES);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned m_base(input logic [31:0] addr, input logic [1:0] size);
        int unsigned a;
        a = addr % BYTES;
        return a - (a % m_nb(size));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] size,
                                           input bit uns);
        int unsigned nb, a;
        logic [31:0] v;
        nb = m_nb(size);
        a  = m_base(addr, size);
        v  = '0;
        for (int i = 0; i < nb; i++) v |= 32'(mem[a + i]) << (8 * i);
        if (!uns && nb < 4 && v[8 * nb - 1]) v |= ~((32'd1 << (8 * nb)) - 1);
        return v;
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata);
        int unsigned a;
        a = m_base(addr, size);
        for (int i = 0; i < m_nb(size); i++) mem[a + i] = wdata[8 * i +: 8];
    endtask

    task automatic m_clear();
        for (int i = 0; i < BYTES; i++) mem[i] = 8'h00;
        pend_v = 1'b0;
    endtask

    // One clock of traffic: drive at negedge, check the previous request's
    // response just after the edge, then record this request in the model.
    task automatic cycle(input bit v, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        @(negedge clk);
        req_valid = v; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        check_eq({tag, "_vld"}, 64'(rsp_valid), 64'(pend_v));
        if (pend_v) begin
            check_eq({tag, "_err"}, 64'(rsp_err), 64'(pend_err));
            check_eq({tag, "_rdata"}, 64'(rsp_rdata), 64'(pend_rdata));
        end
        pend_v = v;
        if (v) begin
            pend_err   = m_err(addr, size);
            pend_rdata = (we || pend_err) ? 32'h0 : m_load(addr, size, uns);
            if (we && !pend_err) m_store(addr, size, wdata);
        end
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, tag);
    endtask

    task automatic load_const(input logic [1:0] size, input bit uns, input logic [31:0] addr,
                              input logic [31:0] exp, input string tag);
        cycle(1'b1, 1'b0, size, uns, addr, 32'h0, tag);
        idle({tag, "_drain"});
        check_eq(tag, 64'(rsp_rdata), 64'(exp));
    endtask

    // Release reset on a negedge and check the sweep completes on edge DEPTH.
    task automatic release_and_poll(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        m_clear();
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            if (k == DEPTH - 1) begin
                check_eq({tag, "_init_early"}, 64'(init_done), 64'd0);
                check_eq({tag, "_ready_early"}, 64'(req_ready), 64'd0);
            end
            if (k == DEPTH) begin
                check_eq({tag, "_init"}, 64'(init_done), 64'd1);
                check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check_eq({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check_eq({tag, "_init_done"}, 64'(init_done), 64'd0);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        w_valid = 1'b0; w_we = 1'b0; w_size = 2'd0; w_unsigned = 1'b0;
        w_addr = '0; w_wdata = '0;
        m_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        release_and_poll("init");

        // Every word reads zero after the sweep.
        for (int w = 0; w < DEPTH; w++) cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, "sweep");
        idle("sweep_drain");

        // Sub-word loads of a stored word.
        cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10");
        load_const(2'd0, 1'b0, 32'h13, 32'hFFFFFFDE, "lb_s13");
        load_const(2'd0, 1'b1, 32'h13, 32'h000000DE, "lbu_13");
        load_const(2'd1, 1'b0, 32'h10, 32'hFFFFBEEF, "lh_s10");

        // Byte merge with back-to-back responses.
        cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "st_w20");
        cycle(1'b1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000005A, "st_b21");
        load_const(2'd2, 1'b0, 32'h20, 32'h11225A44, "lw_20");

        // Error handling / address wrap.
        cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, "st_w0");
`ifdef DMEM_ERR_EN
        cycle(1'b1, 1'b1, 2'd1, 1'b0, 32'h3, 32'h0000FFFF, "st_h03");
        idle("st_h03_drain");
        check_eq("st_h03_err", 64'(rsp_err), 64'd1);
        load_const(2'd2, 1'b0, 32'h0, 32'hCAFEF00D, "lw_0_unchanged");
        cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, "lw_200");
        idle("lw_200_drain");
        check_eq("lw_200_err", 64'(rsp_err), 64'd1);
        check_eq("lw_200_rdata", 64'(rsp_rdata), 64'd0);
`else
        load_const(2'd2, 1'b0, 32'h200, 32'hCAFEF00D, "lw_200_wrap");
        check_eq("lw_200_noerr", 64'(rsp_err), 64'd0);
`endif

        // Randomized traffic with occasional idle cycles.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                idle("rnd_idle");
            end else begin
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 1023));
                if ($urandom_range(0, 1) == 0) a = a & ~32'(m_nb(sz) - 1);
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) == 1'b1 ? 1'b1 : 1'b0,
                      sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
            end
        end
        idle("rnd_drain");

        // Reset while a load is in flight: response dropped, sweep reruns.
        cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10b");
        cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10_inflight");
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        release_and_poll("reinit");
        load_const(2'd2, 1'b0, 32'h10, 32'h00000000, "lw_10_cleared");

        // DW=64 instance: dword store, word loads at the upper/lower halves.
        check_eq("d64_init", 64'(w_init_done), 64'd1);
        @(negedge clk);
        w_valid = 1'b1; w_we = 1'b1; w_size = 2'd3; w_unsigned = 1'b0;
        w_addr = 32'h08; w_wdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        w_we = 1'b0; w_size = 2'd2; w_unsigned = 1'b1; w_addr = 32'h0C;
        @(negedge clk);
        w_unsigned = 1'b0; w_addr = 32'h08;
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        check_eq("d64_lwu_0c_vld", 64'(w_rsp_valid), 64'd1);
        check_eq("d64_lwu_0c", w_rdata, 64'h0000000001234567);
        @(posedge clk);
        #1;
        check_eq("d64_lw_08_vld", 64'(w_rsp_valid), 64'd1);
        check_eq("d64_lw_08", w_rdata, 64'hFFFFFFFF89ABCDEF);
        check_eq("d64_err", 64'(w_rsp_err), 64'd0);
        @(posedge clk);
        #1;
        check_eq("d64_idle_vld", 64'(w_rsp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
